// File: rtl/pipeline24_batch_sequencer_pkg.sv
// Shared widths, FSM state encoding and result record for the 24-pack batch sequencer.
package pipeline24_batch_sequencer_pkg;

  // Pipeline-wide widths (bot-store address space and coefficient counter width).
  localparam int ADDR_WIDTH            = 8;
  localparam int PCOEFF_COUNT_BITWIDTH = 8;

  // Job and result field widths.
  localparam int CNT_W  = 16;
  localparam int TAG_W  = 8;
  localparam int TOP_W  = 128;
  localparam int BOT_W  = 128;
  localparam int SUM_W  = PCOEFF_COUNT_BITWIDTH + 37;
  localparam int PCNT_W = PCOEFF_COUNT_BITWIDTH + 2;

  typedef enum logic [2:0] {
    BATCH_SEQ_STATE_IDLE     = 3'd0,
    BATCH_SEQ_STATE_STREAM   = 3'd1,
    BATCH_SEQ_STATE_DRAIN    = 3'd2,
    BATCH_SEQ_STATE_DONE     = 3'd3,
    BATCH_SEQ_STATE_WAIT_RES = 3'd4,
    BATCH_SEQ_STATE_GRAB     = 3'd5,
    BATCH_SEQ_STATE_OUTPUT   = 3'd6
  } batch_seq_state_e;

  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [SUM_W-1:0]  sum;
    logic [PCNT_W-1:0] count;
  } batch_result_t;

endpackage

// File: rtl/pipeline24_batch_sequencer_if.sv
// Bundles the job, bot-store, pipeline and result buses of the batch sequencer.
// master = the sequencer itself, slave = its surroundings (host, bot store, pipeline).
interface pipeline24_batch_sequencer_if;
  import pipeline24_batch_sequencer_pkg::*;

  // Host job queue
  logic                  job_valid;
  logic                  job_ready;
  logic [TOP_W-1:0]      job_top;
  logic [ADDR_WIDTH-1:0] job_bot_base;
  logic [CNT_W-1:0]      job_bot_count;
  logic [TAG_W-1:0]      job_tag;
  // Bot store
  logic                  bot_rd_en;
  logic [ADDR_WIDTH-1:0] bot_rd_addr;
  logic [BOT_W-1:0]      bot_rd_data;
  // 24-pack pipeline
  logic [TOP_W-1:0]      pipe_top;
  logic [BOT_W-1:0]      pipe_bot;
  logic                  pipe_bot_valid;
  logic                  pipe_batch_done;
  logic                  pipe_slow_down;
  logic                  pipe_grab_results;
  logic                  pipe_results_avail;
  logic [SUM_W-1:0]      pipe_pcoeff_sum;
  logic [PCNT_W-1:0]     pipe_pcoeff_count;
  // Result return
  logic                  res_valid;
  logic                  res_ready;
  logic [TAG_W-1:0]      res_tag;
  logic [SUM_W-1:0]      res_sum;
  logic [PCNT_W-1:0]     res_count;
  logic                  busy;

  modport master (
    input  job_valid, job_top, job_bot_base, job_bot_count, job_tag,
    input  bot_rd_data, pipe_slow_down, pipe_results_avail,
    input  pipe_pcoeff_sum, pipe_pcoeff_count, res_ready,
    output job_ready, bot_rd_en, bot_rd_addr,
    output pipe_top, pipe_bot, pipe_bot_valid, pipe_batch_done, pipe_grab_results,
    output res_valid, res_tag, res_sum, res_count, busy
  );

  modport slave (
    output job_valid, job_top, job_bot_base, job_bot_count, job_tag,
    output bot_rd_data, pipe_slow_down, pipe_results_avail,
    output pipe_pcoeff_sum, pipe_pcoeff_count, res_ready,
    input  job_ready, bot_rd_en, bot_rd_addr,
    input  pipe_top, pipe_bot, pipe_bot_valid, pipe_batch_done, pipe_grab_results,
    input  res_valid, res_tag, res_sum, res_count, busy
  );

endinterface

// File: rtl/pipeline24_batch_sequencer_result_capture.sv
// Result capture: delays the grab pulse by RESULT_LAT cycles, samples the pipeline's
// sum/count at that point and holds them with a valid/ready handshake.
module pipeline24_batch_sequencer_result_capture
  import pipeline24_batch_sequencer_pkg::*;
#(
  parameter int RESULT_LAT = 3
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              grab_i,
  input  logic [SUM_W-1:0]  sum_i,
  input  logic [PCNT_W-1:0] count_i,
  input  logic [TAG_W-1:0]  tag_i,
  input  logic              res_ready_i,
  output logic              load_o,
  output logic              pending_o,
  output logic              res_valid_o,
  output batch_result_t     res_o
);

  logic [RESULT_LAT-1:0] grab_dly_q;
  logic                  res_valid_q;
  batch_result_t         res_q;

  if (RESULT_LAT == 1) begin : g_dly_one
    // Single-stage grab delay.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) grab_dly_q <= '0;
      else         grab_dly_q <= grab_i;
    end
  end else begin : g_dly_many
    // Grab pulse travels down the shift line; the last stage marks valid pipeline outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) grab_dly_q <= '0;
      else         grab_dly_q <= {grab_dly_q[RESULT_LAT-2:0], grab_i};
    end
  end

  assign load_o    = grab_dly_q[RESULT_LAT-1];
  // While a grab is travelling the sequencer must not issue another one.
  assign pending_o = |grab_dly_q;

  // Hold register: load once, stay frozen until the consumer takes it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      res_valid_q <= 1'b0;
      res_q       <= '0;
    end else if (load_o) begin
      res_valid_q <= 1'b1;
      res_q       <= '{tag: tag_i, sum: sum_i, count: count_i};
    end else if (res_valid_q && res_ready_i) begin
      res_valid_q <= 1'b0;
    end
  end

  assign res_valid_o = res_valid_q;
  assign res_o       = res_q;

endmodule

// File: rtl/pipeline24_batch_sequencer.sv
// Batch sequencer: runs one job at a time through the 24-pack pipeline -- streams the
// job's bots from the bot store with top held stable, signals batch end, then grabs and
// returns {tag, sum, count}.
module pipeline24_batch_sequencer
  import pipeline24_batch_sequencer_pkg::*;
#(
  parameter int RD_LAT     = 2,
  parameter int RESULT_LAT = 3
) (
  input logic                          clk_i,
  input logic                          rst_ni,
  pipeline24_batch_sequencer_if.master bus
);

  localparam int INFL_W = $clog2(RD_LAT + 1);

  batch_seq_state_e      state_q, state_d;
  logic [TOP_W-1:0]      top_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [CNT_W-1:0]      remain_q;
  logic [TAG_W-1:0]      tag_q;
  logic [INFL_W-1:0]     inflight_q;
  logic [RD_LAT-1:0]     rd_vld_q;

  logic          accept, issue, ret, grab;
  logic          cap_load, cap_pending, cap_valid;
  batch_result_t cap_res;

  assign accept = (state_q == BATCH_SEQ_STATE_IDLE) && bus.job_valid;
  // Slow-down only throttles new reads; reads already in flight still return.
  assign issue  = (state_q == BATCH_SEQ_STATE_STREAM) && !bus.pipe_slow_down;
  assign ret    = rd_vld_q[RD_LAT-1];
  assign grab   = (state_q == BATCH_SEQ_STATE_GRAB) && !cap_pending;

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= BATCH_SEQ_STATE_IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic for the batch lifecycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      BATCH_SEQ_STATE_IDLE:
        if (bus.job_valid)
          state_d = (bus.job_bot_count != '0) ? BATCH_SEQ_STATE_STREAM : BATCH_SEQ_STATE_DRAIN;
      BATCH_SEQ_STATE_STREAM:
        if (issue && (remain_q == CNT_W'(1))) state_d = BATCH_SEQ_STATE_DRAIN;
      BATCH_SEQ_STATE_DRAIN:
        if (inflight_q == '0) state_d = BATCH_SEQ_STATE_DONE;
      BATCH_SEQ_STATE_DONE:
        state_d = BATCH_SEQ_STATE_WAIT_RES;
      BATCH_SEQ_STATE_WAIT_RES:
        if (bus.pipe_results_avail) state_d = BATCH_SEQ_STATE_GRAB;
      BATCH_SEQ_STATE_GRAB:
        if (cap_load) state_d = BATCH_SEQ_STATE_OUTPUT;
      BATCH_SEQ_STATE_OUTPUT:
        if (cap_valid && bus.res_ready) state_d = BATCH_SEQ_STATE_IDLE;
      default:
        state_d = BATCH_SEQ_STATE_IDLE;
    endcase
  end

  // Job latch and read address / remaining-count walk; address wraps naturally.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      top_q    <= '0;
      addr_q   <= '0;
      remain_q <= '0;
      tag_q    <= '0;
    end else if (accept) begin
      top_q    <= bus.job_top;
      addr_q   <= bus.job_bot_base;
      remain_q <= bus.job_bot_count;
      tag_q    <= bus.job_tag;
    end else if (issue) begin
      addr_q   <= addr_q + ADDR_WIDTH'(1);
      remain_q <= remain_q - CNT_W'(1);
    end
  end

  if (RD_LAT == 1) begin : g_rdv_one
    // Read strobe aligned to the single-cycle bot-store latency.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) rd_vld_q <= '0;
      else         rd_vld_q <= issue;
    end
  end else begin : g_rdv_many
    // Read strobe delayed to line up with returning bot-store data.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) rd_vld_q <= '0;
      else         rd_vld_q <= {rd_vld_q[RD_LAT-2:0], issue};
    end
  end

  // Reads issued but not yet returned; DRAIN waits for this to empty.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)            inflight_q <= '0;
    else if (issue && !ret) inflight_q <= inflight_q + INFL_W'(1);
    else if (!issue && ret) inflight_q <= inflight_q - INFL_W'(1);
  end

  pipeline24_batch_sequencer_result_capture #(
    .RESULT_LAT (RESULT_LAT)
  ) u_capture (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .grab_i      (grab),
    .sum_i       (bus.pipe_pcoeff_sum),
    .count_i     (bus.pipe_pcoeff_count),
    .tag_i       (tag_q),
    .res_ready_i (bus.res_ready),
    .load_o      (cap_load),
    .pending_o   (cap_pending),
    .res_valid_o (cap_valid),
    .res_o       (cap_res)
  );

  assign bus.job_ready         = (state_q == BATCH_SEQ_STATE_IDLE);
  assign bus.busy              = (state_q != BATCH_SEQ_STATE_IDLE);
  assign bus.bot_rd_en         = issue;
  assign bus.bot_rd_addr       = addr_q;
  assign bus.pipe_top          = top_q;
  assign bus.pipe_bot_valid    = ret;
  assign bus.pipe_bot          = ret ? bus.bot_rd_data : '0;
  assign bus.pipe_batch_done   = (state_q == BATCH_SEQ_STATE_DONE);
  assign bus.pipe_grab_results = grab;
  assign bus.res_valid         = cap_valid;
  assign bus.res_tag           = cap_res.tag;
  assign bus.res_sum           = cap_res.sum;
  assign bus.res_count         = cap_res.count;

endmodule

// File: tb/tb_pipeline24_batch_sequencer.sv
// Bench for the batch sequencer: models the bot store and the 24-pack pipeline, drives
// directed and random jobs, and checks bots/results against queued expectations.
module tb_pipeline24_batch_sequencer;
  import pipeline24_batch_sequencer_pkg::*;

  localparam int RD_LAT     = 2;
  localparam int RESULT_LAT = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pipeline24_batch_sequencer_if bus();

  pipeline24_batch_sequencer #(.RD_LAT(RD_LAT), .RESULT_LAT(RESULT_LAT)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  int n_pass  = 0;
  int n_total = 0;

  logic [BOT_W-1:0] mem [0:255];
  logic [BOT_W-1:0] exp_bot_q [$];
  batch_result_t    exp_res_q [$];
  logic [TOP_W-1:0] exp_top;

  int   avail_delay_cfg = 2;
  int   rdy_wait        = 0;
  int   slow_mode       = 0;   // 0 never, 1 random, 2 follow slow_force
  logic slow_force      = 1'b0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- bot store + pipeline behavioural model ----------------
  logic                  st_v;
  logic [ADDR_WIDTH-1:0] st_a;
  logic                  avail_arm;
  int                    avail_cnt;
  int                    age;
  logic [SUM_W-1:0]      acc_sum, batch_sum;
  logic [PCNT_W-1:0]     acc_cnt, batch_cnt;

  always @(posedge clk) begin
    st_v <= bus.bot_rd_en;
    st_a <= bus.bot_rd_addr;
    bus.bot_rd_data <= st_v ? mem[st_a] : rand128();
    if ((RESULT_LAT == 1) ? bus.pipe_grab_results : (age == RESULT_LAT - 1)) begin
      bus.pipe_pcoeff_sum   <= batch_sum;
      bus.pipe_pcoeff_count <= batch_cnt;
    end else begin
      bus.pipe_pcoeff_sum   <= SUM_W'({$urandom, $urandom});
      bus.pipe_pcoeff_count <= PCNT_W'($urandom);
    end
    if (!rst_n) begin
      acc_sum <= '0; acc_cnt <= '0; batch_sum <= '0; batch_cnt <= '0;
      avail_arm <= 1'b0; avail_cnt <= 0; age <= 0;
      bus.pipe_results_avail <= 1'b0;
    end else begin
      if (bus.pipe_bot_valid) begin
        acc_sum <= acc_sum + SUM_W'(bus.pipe_bot[15:0]);
        acc_cnt <= acc_cnt + PCNT_W'(1);
      end
      if (bus.pipe_batch_done) begin
        batch_sum <= acc_sum; batch_cnt <= acc_cnt;
        acc_sum <= '0; acc_cnt <= '0;
        avail_arm <= 1'b1; avail_cnt <= avail_delay_cfg;
      end else if (avail_arm) begin
        if (avail_cnt == 0) begin
          bus.pipe_results_avail <= 1'b1;
          avail_arm <= 1'b0;
        end else avail_cnt <= avail_cnt - 1;
      end
      if (bus.pipe_grab_results) begin
        bus.pipe_results_avail <= 1'b0;
        age <= 1;
      end else if (age != 0 && age < RESULT_LAT) age <= age + 1;
      else age <= 0;
    end
  end

  // ---------------- slow-down / result-ready drivers ----------------
  initial begin
    bus.pipe_slow_down = 1'b0;
    bus.res_ready      = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (slow_mode)
        0:       bus.pipe_slow_down = 1'b0;
        1:       bus.pipe_slow_down = ($urandom_range(0, 2) == 0);
        default: bus.pipe_slow_down = slow_force;
      endcase
      bus.res_ready = bus.res_valid && (rdy_wait == 0);
      if (bus.res_valid && rdy_wait > 0) rdy_wait--;
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic          grab_prev, hold_prev;
    batch_result_t held, got, r;
    logic [127:0]  e;
    int            reads_seen, cur_count, done_seen;
    grab_prev = 0; hold_prev = 0; held = '0;
    reads_seen = 0; cur_count = 0; done_seen = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        grab_prev = 0; hold_prev = 0; reads_seen = 0; done_seen = 0;
      end else begin
        got = '{tag: bus.res_tag, sum: bus.res_sum, count: bus.res_count};
        check("ready_vs_busy", bus.job_ready, !bus.busy);
        if (bus.job_valid && bus.job_ready) begin
          reads_seen = 0; done_seen = 0; cur_count = int'(bus.job_bot_count);
        end
        if (bus.pipe_slow_down) check("rd_en_stalled", bus.bot_rd_en, 1'b0);
        if (bus.bot_rd_en) reads_seen++;
        if (bus.pipe_bot_valid) begin
          if (exp_bot_q.size() == 0) check("bot_extra", bus.pipe_bot_valid, 1'b0);
          else begin
            e = exp_bot_q.pop_front();
            check("bot_data", bus.pipe_bot, e);
          end
          check("top_stable_stream", bus.pipe_top, exp_top);
        end
        if (bus.pipe_batch_done) begin
          check("done_once", done_seen, 0);
          done_seen++;
          check("done_after_bots", exp_bot_q.size(), 0);
          check("read_count", reads_seen, cur_count);
          check("valid_low_at_done", bus.pipe_bot_valid, 1'b0);
        end
        if (bus.pipe_grab_results) check("grab_width", grab_prev, 1'b0);
        grab_prev = bus.pipe_grab_results;
        if (hold_prev) begin
          check("res_hold_valid", bus.res_valid, 1'b1);
          check("res_hold_data", got, held);
        end
        if (bus.res_valid) check("job_ready_in_output", bus.job_ready, 1'b0);
        if (bus.res_valid && bus.res_ready) begin
          if (exp_res_q.size() == 0) check("res_extra", bus.res_valid, 1'b0);
          else begin
            r = exp_res_q.pop_front();
            $display("result tag=%0d sum=%0d count=%0d (expected tag=%0d sum=%0d count=%0d)",
                     got.tag, got.sum, got.count, r.tag, r.sum, r.count);
            check("res_tag", got.tag, r.tag);
            check("res_sum", got.sum, r.sum);
            check("res_count", got.count, r.count);
          end
          check("done_count_at_result", done_seen, 1);
          check("top_stable_result", bus.pipe_top, exp_top);
        end
        hold_prev = bus.res_valid && !bus.res_ready;
        held      = got;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic pulse_reset();
    @(posedge clk); #2;
    rst_n = 1'b0;
    exp_bot_q.delete();
    exp_res_q.delete();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic start_job(input logic [ADDR_WIDTH-1:0] base, input logic [CNT_W-1:0] cnt,
                           input logic [TAG_W-1:0] tag, input logic [TOP_W-1:0] top);
    batch_result_t         r;
    logic [ADDR_WIDTH-1:0] a;
    logic [SUM_W-1:0]      s;
    int                    guard;
    guard = 0;
    while (!bus.job_ready && guard < 5000) begin @(posedge clk); #1; guard++; end
    if (!bus.job_ready) check("job_ready_timeout", bus.job_ready, 1'b1);
    a = base; s = '0;
    for (int i = 0; i < int'(cnt); i++) begin
      exp_bot_q.push_back(mem[a]);
      s = s + SUM_W'(mem[a][15:0]);
      a = a + ADDR_WIDTH'(1);
    end
    r.tag = tag; r.sum = s; r.count = PCNT_W'(cnt);
    exp_res_q.push_back(r);
    exp_top = top;
    $display("job tag=%0d base=%0d count=%0d", tag, base, cnt);
    bus.job_valid = 1'b1; bus.job_top = top; bus.job_bot_base = base;
    bus.job_bot_count = cnt; bus.job_tag = tag;
    @(posedge clk); #1;
    bus.job_valid = 1'b0; bus.job_top = rand128();
    bus.job_bot_base = ADDR_WIDTH'($urandom); bus.job_bot_count = CNT_W'($urandom);
    bus.job_tag = TAG_W'($urandom);
  endtask

  task automatic wait_done();
    int guard;
    guard = 0;
    while ((exp_res_q.size() != 0 || !bus.job_ready) && guard < 4000) begin
      @(posedge clk); #1; guard++;
    end
    if (guard >= 4000) begin
      check("job_timeout", exp_res_q.size(), 0);
      pulse_reset();
    end
  endtask

  task automatic run_job(input logic [ADDR_WIDTH-1:0] base, input logic [CNT_W-1:0] cnt,
                         input logic [TAG_W-1:0] tag, input logic [TOP_W-1:0] top);
    start_job(base, cnt, tag, top);
    wait_done();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = rand128();
    bus.job_valid = 1'b0; bus.job_top = '0; bus.job_bot_base = '0;
    bus.job_bot_count = '0; bus.job_tag = '0;

    // Reset state
    @(posedge clk); #1;
    check("reset_ctrl", {bus.bot_rd_en, bus.pipe_bot_valid, bus.pipe_batch_done,
                         bus.pipe_grab_results, bus.res_valid, bus.busy, bus.job_ready},
          7'b0000001);
    check("reset_top", bus.pipe_top, '0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: basic five-bot batch
    run_job(8'h10, 16'd5, 8'd1, rand128());
    // 2: empty batch
    avail_delay_cfg = 0;
    run_job(8'h80, 16'd0, 8'd2, rand128());
    // 3: long batch with a ten-cycle stall mid-stream
    avail_delay_cfg = 3;
    fork
      run_job(8'h20, 16'd100, 8'd3, rand128());
      begin
        repeat (20) @(posedge clk);
        slow_force = 1'b1; slow_mode = 2;
        repeat (10) @(posedge clk);
        slow_force = 1'b0; slow_mode = 0;
      end
    join
    // 4: late results, consumer holds off for seven cycles
    avail_delay_cfg = 20; rdy_wait = 7;
    run_job(8'h40, 16'd6, 8'd4, rand128());
    // 5: asynchronous reset while streaming, then a clean job
    avail_delay_cfg = 2;
    start_job(8'h00, 16'd60, 8'd5, rand128());
    repeat (8) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_ctrl", {bus.bot_rd_en, bus.pipe_bot_valid, bus.pipe_batch_done,
                          bus.pipe_grab_results, bus.res_valid, bus.busy, bus.job_ready},
          7'b0000001);
    check("midrst_top", bus.pipe_top, '0);
    check("midrst_addr", bus.bot_rd_addr, '0);
    check("midrst_res", {bus.res_tag, bus.res_sum, bus.res_count}, '0);
    exp_bot_q.delete();
    exp_res_q.delete();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    run_job(8'h30, 16'd7, 8'd6, rand128());
    // 6: address wrap
    run_job(8'hFE, 16'd4, 8'd7, rand128());
    // Random jobs with random slow-down, result latency and consumer back-pressure
    for (int j = 0; j < 12; j++) begin
      slow_mode = 1;
      rdy_wait = $urandom_range(0, 3);
      avail_delay_cfg = $urandom_range(0, 8);
      run_job(ADDR_WIDTH'($urandom), CNT_W'($urandom_range(0, 40)), TAG_W'($urandom), rand128());
    end
    slow_mode = 0;
    repeat (5) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
